// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared constants and state encoding for the round-robin demux feeder.
package demux_rr_dispatcher_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/demux_hold_timer.sv
// Counts cycles a word waits in HOLD; flags the last allowed wait cycle.
module demux_hold_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] r_wait_cnt;

  // Counter only runs while a word is stuck; any other cycle restarts it.
  always_ff @(posedge clk) begin
    if (rst || i_clr)  r_wait_cnt <= '0;
    else if (i_en)     r_wait_cnt <= r_wait_cnt + 1'b1;
    else               r_wait_cnt <= '0;
  end

  assign o_expire = (TIMEOUT > 0) && i_en && (r_wait_cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/demux_rr_dispatcher.sv
// Valid/ready front end for a 1-to-4 demux: one-entry hold register,
// round-robin or addressed channel choice, and hold timeout drop.
module demux_rr_dispatcher
  import demux_rr_dispatcher_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_addr_en,
  input  logic [SEL_W-1:0]  in_addr,
  input  logic [N_CH-1:0]   ch_ready,
  output logic              out_valid,
  output logic [SEL_W-1:0]  out_sel,
  output logic [DATA_W-1:0] out_d,
  output logic              out_drop
);
  state_e             r_state;
  state_e             w_state_nxt;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic [DATA_W-1:0]  r_d;
  logic               r_drop;
  logic [SEL_W-1:0]   w_chan;
  logic               w_transfer;
  logic               w_accept;
  logic               w_wait;
  logic               w_expire;

  assign w_transfer = (r_state == HOLD) && ch_ready[r_sel];
  assign in_ready   = !rst && ((r_state == IDLE) || w_transfer);
  assign w_accept   = in_valid && in_ready;
  assign w_chan     = in_addr_en ? in_addr : r_rr_ptr;
  assign w_wait     = (r_state == HOLD) && !w_transfer;

  demux_hold_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_accept),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)                     w_state_nxt = HOLD;
    else if (w_transfer || w_expire)  w_state_nxt = IDLE;
  end

  // Expiry is only possible without a transfer, so the drop pulse never
  // coincides with a delivered word; accept cannot occur while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d      <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_expire;
      if (w_accept) begin
        r_d   <= in_data;
        r_sel <= w_chan;
        if (!in_addr_en) r_rr_ptr <= w_chan + 2'd1;
      end else if (w_transfer || w_expire) begin
        r_d <= '0;
      end
    end
  end

  assign out_valid = (r_state == HOLD);
  assign out_sel   = r_sel;
  assign out_d     = r_d;
  assign out_drop  = r_drop;
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench: dut_a (TIMEOUT=16) for routing/backpressure, dut_b (TIMEOUT=4) for drops.
module tb_demux_rr_dispatcher;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_addr_en;
  logic [1:0] in_addr;
  logic [3:0] ch_ready;

  logic       a_in_ready, a_out_valid, a_out_drop;
  logic [1:0] a_out_sel;
  logic [7:0] a_out_d;
  logic       b_in_ready, b_out_valid, b_out_drop;
  logic [1:0] b_out_sel;
  logic [7:0] b_out_d;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  demux_rr_dispatcher #(.DATA_W(8), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_addr_en(in_addr_en), .in_addr(in_addr),
    .ch_ready(ch_ready), .out_valid(a_out_valid), .out_sel(a_out_sel),
    .out_d(a_out_d), .out_drop(a_out_drop)
  );

  demux_rr_dispatcher #(.DATA_W(8), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_addr_en(in_addr_en), .in_addr(in_addr),
    .ch_ready(ch_ready), .out_valid(b_out_valid), .out_sel(b_out_sel),
    .out_d(b_out_d), .out_drop(b_out_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic aen, input logic [1:0] a);
    in_valid = 1'b1; in_data = d; in_addr_en = aen; in_addr = a;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h11; in_addr_en = 1'b0;
    in_addr = 2'd0; ch_ready = 4'hF;

    // Reset with a pending word: nothing accepted, all outputs quiet
    tick(); tick();
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_sel", a_out_sel, 0);
    chk("rst_out_d", a_out_d, 0);
    chk("rst_out_drop", a_out_drop, 0);

    // Round robin, back to back, all channels ready
    rst = 1'b0; #1;
    chk("rr_in_ready", a_in_ready, 1);
    tick();
    chk("rr0_valid", a_out_valid, 1);
    chk("rr0_sel", a_out_sel, 0);
    chk("rr0_d", a_out_d, 8'h11);
    in_data = 8'h22; #1;
    chk("rr_tie_ready", a_in_ready, 1);
    tick();
    chk("rr1_sel", a_out_sel, 1);
    chk("rr1_d", a_out_d, 8'h22);
    in_data = 8'h33; tick();
    chk("rr2_sel", a_out_sel, 2);
    chk("rr2_valid", a_out_valid, 1);
    in_data = 8'h44; tick();
    chk("rr3_sel", a_out_sel, 3);
    chk("rr3_d", a_out_d, 8'h44);
    in_data = 8'h55; tick();
    chk("rr4_wrap_sel", a_out_sel, 0);
    chk("rr4_d", a_out_d, 8'h55);
    in_valid = 1'b0; tick();
    chk("drain_valid", a_out_valid, 0);
    chk("drain_d", a_out_d, 0);
    chk("drain_sel_hold", a_out_sel, 0);

    // Addressed word between RR words leaves the pointer alone
    rst = 1'b1; tick(); rst = 1'b0;
    send(8'h66, 1'b0, 2'd0); tick();
    chk("mix0_sel", a_out_sel, 0);
    send(8'h77, 1'b1, 2'd3); tick();
    chk("mix1_sel", a_out_sel, 3);
    chk("mix1_d", a_out_d, 8'h77);
    send(8'h88, 1'b0, 2'd0); tick();
    chk("mix2_sel", a_out_sel, 1);
    in_valid = 1'b0; tick();
    chk("mix_idle", a_out_valid, 0);

    // Backpressure on ch1 for 5 cycles, then released
    ch_ready = 4'b1101;
    send(8'h99, 1'b1, 2'd1); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", a_out_valid, 1);
      chk("bp_drop", a_out_drop, 0);
      chk("bp_in_ready", a_in_ready, 0);
      if (i == 4) ch_ready = 4'hF;
      tick();
    end
    chk("bp_done_valid", a_out_valid, 0);
    chk("bp_done_drop", a_out_drop, 0);
    chk("bp_done_d", a_out_d, 0);

    // Timeout: ch1 stalled, TIMEOUT=4 drops after 4 HOLD cycles
    rst = 1'b1; tick(); rst = 1'b0;
    ch_ready = 4'b1101;
    send(8'hAA, 1'b1, 2'd1); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_valid", b_out_valid, 1);
      chk("to_drop_early", b_out_drop, 0);
      if (i == 3) chk("to_in_ready", b_in_ready, 0);
      tick();
    end
    chk("to_drop", b_out_drop, 1);
    chk("to_valid_after", b_out_valid, 0);
    chk("to_d_after", b_out_d, 0);
    tick();
    chk("to_drop_once", b_out_drop, 0);

    // Flush dut_a, then tie: transfer and new accept in the expiry cycle
    ch_ready = 4'hF; tick();
    ch_ready = 4'b1101;
    send(8'hBB, 1'b1, 2'd1); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tie_valid", b_out_valid, 1);
      tick();
    end
    ch_ready = 4'hF;
    send(8'hCC, 1'b1, 2'd2); #1;
    chk("tie_in_ready", b_in_ready, 1);
    tick();
    chk("tie_drop", b_out_drop, 0);
    chk("tie_valid_new", b_out_valid, 1);
    chk("tie_sel_new", b_out_sel, 2);
    chk("tie_d_new", b_out_d, 8'hCC);
    in_valid = 1'b0; tick();

    // Mid-operation reset drops silently and rewinds the RR pointer
    ch_ready = 4'b1101;
    send(8'hDD, 1'b1, 2'd1); tick();
    in_valid = 1'b0; tick();
    chk("mr_held", a_out_valid, 1);
    rst = 1'b1; tick();
    chk("mr_valid", a_out_valid, 0);
    chk("mr_drop_a", a_out_drop, 0);
    chk("mr_drop_b", b_out_drop, 0);
    rst = 1'b0; ch_ready = 4'hF;
    send(8'hEE, 1'b0, 2'd0); tick();
    chk("mr_rr_sel", a_out_sel, 0);
    chk("mr_rr_d", a_out_d, 8'hEE);
    in_valid = 1'b0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
- Upstream feeder for the 1-to-4 demultiplexer (DEMUX_1_to_4).
- Accepts data words over a valid/ready handshake and picks a destination channel for each word. The channel is either the addressed one or the next in round-robin order.
- Holds each word in a one-entry output register and drives the demux data and select inputs until the chosen channel accepts the word.
- A programmable hold timeout drops words bound for a stalled channel, so one dead consumer cannot block the other three.

Parameters:
- DATA_W, 1, width of the data word; matches the demux D input width.
- TIMEOUT, 16, maximum cycles a word may wait in HOLD before it is dropped; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  dispatcher can accept a word this cycle.
- in_data  in  DATA_W  upstream word.
- in_addr_en  in  1  1 = use in_addr as the channel; 0 = round-robin.
- in_addr  in  2  explicit channel, used when in_addr_en=1.
- ch_ready  in  4  per-channel consumer ready, one bit per demux output Y[3:0].
- out_valid  out  1  a word is held and presented to the demux.
- out_sel  out  2  drives demux S.
- out_d  out  DATA_W  drives demux D; equals the held word when out_valid=1, otherwise 0.
- out_drop  out  1  one-cycle pulse when a held word is discarded by timeout.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values: out_valid=0, out_sel=0, out_d=0, out_drop=0, rr_ptr=0, wait_cnt=0, state=IDLE.
- in_ready is forced to 0 while rst=1.
- Reset mid-operation: any held word is discarded silently; out_drop is not pulsed.
- States:
  - IDLE: nothing held.
  - HOLD: word held; out_valid=1.
- Transfer: occurs in a cycle where state=HOLD and ch_ready[out_sel]=1. The consumer latches out_d on that edge.
- in_ready (combinational) = (state==IDLE) OR transfer, so a word can be accepted in the same cycle the previous word leaves.
- Accept (in_valid AND in_ready):
  - Register in_data into out_d.
  - Set chan = in_addr_en ? in_addr : rr_ptr; write chan into out_sel.
  - Go to HOLD and clear wait_cnt.
  - Accept-to-out_valid latency is 1 cycle.
- Round-robin pointer:
  - On an accept with in_addr_en=0, rr_ptr <= chan+1 mod 4 (3 wraps to 0).
  - Addressed accepts leave rr_ptr unchanged.
- Transfer with no accept: go to IDLE, out_valid=0, out_d=0. out_sel holds its last value.
- Timeout:
  - In HOLD with no transfer, wait_cnt increments each cycle.
  - If TIMEOUT>0 and wait_cnt==TIMEOUT-1 with no transfer, then on the next edge: drop the word, pulse out_drop=1 for one cycle, go to IDLE.
  - A word therefore occupies HOLD for at most TIMEOUT cycles.
  - in_ready is 0 in the drop cycle; the new accept happens from IDLE on the following cycle.
- Simultaneous events:
  - Transfer and timeout expiry in the same cycle: transfer wins and out_drop stays 0.
  - Transfer and accept in the same cycle: the new word replaces the old with no bubble; out_valid stays 1.
- ch_ready bits other than ch_ready[out_sel] are ignored.
- in_data, in_addr and in_addr_en are sampled only on accept.
- wait_cnt width: $clog2(TIMEOUT+1), minimum 1 bit.

Decomposition:
- Shared package contains:
  - Constants N_CH=4 and SEL_W=2.
  - State typedef {IDLE, HOLD} as localparam encodings (IDLE=1'b0, HOLD=1'b1).
- One sub-module, demux_hold_timer: wait_cnt, clear/enable inputs, and the expire output. The remaining logic is a flat FSM plus datapath.
- Top-level integration instantiates this block alongside DEMUX_1_to_4, wiring D and S directly.

Test Plan:
- Reset: assert rst with in_valid=1 held -> in_ready=0 and all outputs 0. Release -> first RR word goes to out_sel=0.
- Round-robin with ch_ready=4'b1111: feed in_data=1,1,1,1,1 back-to-back -> out_sel sequence 0,1,2,3,0, one word per cycle. Demux Y is one-hot 0001,0010,0100,1000,0001 with no bubbles.
- Addressed mix:
  - Stimulus: RR word, then addr word (in_addr=3), then RR word.
  - Response: out_sel = 0, 3, 1 (rr_ptr is unaffected by the addressed word).
- Backpressure:
  - Stimulus: ch_ready=4'b1101, word routed to ch1; raise ch_ready[1] after 5 cycles.
  - Response: out_valid is held 5 cycles, then the transfer occurs, and out_drop stays 0.
- Timeout and tie:
  - TIMEOUT=4 with ch1 stalled -> out_drop pulses once, exactly 4 cycles after the accept; out_valid=0 afterwards.
  - Repeat with ch_ready[1] rising in the expiry cycle -> transfer occurs and out_drop=0.
- Mid-operation reset: assert rst while in HOLD -> out_valid=0 next cycle, no out_drop pulse, and rr_ptr returns to 0.
